anb_rd_splitter_m: RTL
======================

// Module: anb_rd_splitter_m
// PURPOSE
//  Read-path counterpart of the ANB write splitter. Sits between a read initiator (m_*) and a
//  read target (s_*). Each incoming read burst is split into sub-bursts of at most MAX_BURST beats.
//  Returned read data is passed back in order, with m_d.last re-generated so that it is asserted
//  only on the final beat of the original burst.
// PARAMETERS
//  ADDR_T       -        address type; byte address; arithmetic is modulo 2**$bits(ADDR_T)
//  LEN_T        -        burst length type; len = beats-1
//  DATA_T       -        read data beat type; BEAT_BYTES = $bits(DATA_T)/8 (derived localparam)
//  MAX_BURST    16       max beats per sub-burst; power of two, <= 2**$bits(LEN_T)
//  OUTSTANDING  4        max sub-bursts issued but not fully returned (tag FIFO depth)
// PORTS
//  clk        in   1         clock
//  rst        in   1         reset (sync, active-high)
//  m_a        anb_addr_channel_if.s   read request from initiator (avalid, aready, addr, len)
//  s_a        anb_addr_channel_if.m   sub-burst requests to target
//  s_d        anb_data_channel_if.s   read data from target (valid, ready, data, last)
//  m_d        anb_data_channel_if.m   read data to initiator
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset: s_a.avalid=0, m_d.valid=0, m_a.aready=0, s_d.ready=0, FSM=IDLE, tag FIFO empty.
//   Reset mid-operation discards all state; in-flight data is not tracked afterwards.
//  Handshake: a transfer occurs on valid&&ready. Valid never depends combinationally on ready.
//   Payload is held stable while valid && !ready.
//  Address FSM:
//   IDLE:  m_a.aready=1. On handshake, latch addr to cur_addr and set rem=len+1.
//          rem is $bits(LEN_T)+1 wide, so len=max causes no overflow. Go to ISSUE.
//   ISSUE: chunk=min(rem,MAX_BURST). s_a.addr=cur_addr, s_a.len=chunk-1.
//          s_a.avalid = !tag_full, using registered occupancy.
//          On s_a handshake:
//            - push tag {final = (rem<=MAX_BURST)};
//            - cur_addr += chunk*BEAT_BYTES (wraps);
//            - rem -= chunk;
//            - if final, go to IDLE, else stay in ISSUE.
//   Latency: m_a accepted at cycle N; first s_a.avalid at N+1 (if not full).
//   Sub-bursts are then issued back to back, one per cycle, when s_a.aready=1.
//   Only one original burst is split at a time. The next burst is accepted in the cycle after the
//   final sub-burst handshake.
//  Data path: s_d passes through one reg_stage_m slice, giving one cycle of latency at full
//   throughput. The slice input takes data and last_out = s_d.last && tag_head.final.
//   Tag pop occurs on an s_d handshake with s_d.last=1.
//   Simultaneous push and pop on a full FIFO is allowed; the freed slot becomes visible to
//   avalid the next cycle.
//  Boundary conditions:
//   - len=0: one sub-burst with len=0; m_d.last is set on that single beat.
//   - rem == MAX_BURST exactly: one sub-burst, final=1.
//   - s_d.valid while the tag FIFO is empty is a protocol violation. The data is still forwarded
//     with last=0, and an SVA assertion fires.
//   - s_d.ready = slice ready; it does not depend on the FSM.
// STRUCTURE
//  anb_pkg (shared):
//   - anb_rd_tag_t {logic final};
//   - function clog2-safe width helpers;
//   - localparam-free. Type-parameterised structs stay local, because they depend on ADDR_T,
//     LEN_T and DATA_T.
//  Sub-modules:
//   - anb_tag_fifo_m: sync FIFO, DEPTH=OUTSTANDING, with full/empty/count. This is the natural
//     sub-module.
//   - reg_stage_m is reused for the output data slice.
// TESTING  (DATA_T=32b, BEAT_BYTES=4, MAX_BURST=16, OUTSTANDING=4)
//  1. addr=0x100, len=9 -> one s_a {0x100,9}. m_d.last only on beat 10.
//  2. addr=0x1000, len=39 -> s_a {0x1000,15}, {0x1040,15}, {0x1080,7}.
//     s_d.last occurs 3 times; m_d.last occurs once, on beat 40.
//  3. s_d.valid=0, len=255 -> exactly 4 s_a handshakes, then avalid=0.
//     The 5th sub-burst is issued 1 cycle after the first sub-burst's last beat is accepted.
//  4. len=47, random 50% m_d.ready and s_a.aready -> 48 beats, in order, no loss or duplication,
//     a single m_d.last.
//  5. addr=0xFFFF_FFC0 (32b ADDR_T), len=31 -> s_a {0xFFFF_FFC0,15}, {0x0000_0000,15}.
//  6. rst pulsed mid-burst (test 2) -> next cycle s_a.avalid=0, m_d.valid=0, m_a.aready=0.
//     After release, m_a.aready=1 and the FIFO is empty.

Source files
------------

// File: rtl/anb_pkg.sv
// Shared ANB types and width helpers used by the read splitter and its tag FIFO.
package anb_pkg;

    typedef struct packed {
        logic is_final;   // sub-burst carries the last beat of the original burst
    } anb_rd_tag_t;

    // Index width that stays at least 1 bit for single-entry storage.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width able to hold the values 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/anb_tag_fifo_m.sv
// Synchronous tag FIFO with registered full/empty/count; tracks issued sub-bursts.
module anb_tag_fifo_m
    import anb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  anb_rd_tag_t                      push_tag,
    input  logic                             pop,
    output anb_rd_tag_t                      head,
    output logic                             full,
    output logic                             empty,
    output logic [cnt_width(DEPTH)-1:0]      count
);

    typedef logic [idx_width(DEPTH)-1:0] ptr_t;
    typedef logic [cnt_width(DEPTH)-1:0] cnt_t;

    anb_rd_tag_t mem [DEPTH];
    ptr_t        wr_ptr;
    ptr_t        rd_ptr;
    cnt_t        count_nxt;
    logic        do_push;
    logic        do_pop;

    function automatic ptr_t bump(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop)
            count_nxt = count + cnt_t'(1);
        else if (do_pop && !do_push)
            count_nxt = count - cnt_t'(1);
    end

    // NOTE: tag storage has no reset; entries are only read after being written, and the pointers are reset.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_tag;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push)
                wr_ptr <= bump(wr_ptr);
            if (do_pop)
                rd_ptr <= bump(rd_ptr);
            count <= count_nxt;
            full  <= (count_nxt == cnt_t'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/reg_stage_m.sv
// Full-throughput pipeline register slice: one cycle of latency, valid/ready on both sides.
module reg_stage_m #(
    parameter type T = logic [31:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic s_valid,
    output logic s_ready,
    input  T     s_data,
    output logic m_valid,
    input  logic m_ready,
    output T     m_data
);

    logic running;

    // Ready stays low while in reset and for the first cycle after it.
    assign s_ready = running && (!m_valid || m_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            m_valid <= 1'b0;
        end else begin
            running <= 1'b1;
            if (s_ready)
                m_valid <= s_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (s_valid && s_ready)
            m_data <= s_data;
    end

endmodule

// File: rtl/anb_rd_splitter_m.sv
// Splits ANB read bursts into sub-bursts of at most MAX_BURST beats and re-generates
// the read-data last flag so it marks only the final beat of the original burst.
module anb_rd_splitter_m
    import anb_pkg::*;
#(
    parameter type         ADDR_T      = logic [31:0],
    parameter type         LEN_T       = logic [7:0],
    parameter type         DATA_T      = logic [31:0],
    parameter int unsigned MAX_BURST   = 16,
    parameter int unsigned OUTSTANDING = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  m_a_avalid,
    output logic  m_a_aready,
    input  ADDR_T m_a_addr,
    input  LEN_T  m_a_len,
    output logic  s_a_avalid,
    input  logic  s_a_aready,
    output ADDR_T s_a_addr,
    output LEN_T  s_a_len,
    input  logic  s_d_valid,
    output logic  s_d_ready,
    input  DATA_T s_d_data,
    input  logic  s_d_last,
    output logic  m_d_valid,
    input  logic  m_d_ready,
    output DATA_T m_d_data,
    output logic  m_d_last
);

    localparam int unsigned BEAT_BYTES = $bits(DATA_T) / 8;
    localparam int unsigned LW         = $bits(LEN_T);

    typedef logic [LW:0] rem_t;   // one extra bit so len = max gives beats without overflow
    typedef logic [cnt_width(OUTSTANDING)-1:0] cnt_t;
    typedef struct packed {
        DATA_T data;
        logic  last;
    } beat_t;
    typedef enum logic { IDLE, ISSUE } state_t;

    localparam rem_t MAX_CHUNK = rem_t'(MAX_BURST);

    state_t      state;
    ADDR_T       cur_addr;
    rem_t        rem;
    rem_t        chunk;
    logic        is_final;
    logic        aready_q;
    logic        a_fire;
    anb_rd_tag_t tag_head;
    logic        tag_full;
    logic        tag_empty;
    cnt_t        tag_count;
    beat_t       d_in;
    beat_t       d_out;

    assign is_final   = (rem <= MAX_CHUNK);
    assign chunk      = is_final ? rem : MAX_CHUNK;
    assign m_a_aready = aready_q;
    assign s_a_avalid = (state == ISSUE) && !tag_full;
    assign s_a_addr   = cur_addr;
    assign s_a_len    = LEN_T'(chunk - rem_t'(1));
    assign a_fire     = s_a_avalid && s_a_aready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            aready_q <= 1'b0;
            cur_addr <= '0;
            rem      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (aready_q && m_a_avalid) begin
                        cur_addr <= m_a_addr;
                        rem      <= rem_t'(m_a_len) + rem_t'(1);
                        aready_q <= 1'b0;
                        state    <= ISSUE;
                    end else begin
                        aready_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (a_fire) begin
                        cur_addr <= cur_addr + ADDR_T'(chunk) * ADDR_T'(BEAT_BYTES);
                        rem      <= rem - chunk;
                        if (is_final) begin
                            state    <= IDLE;
                            aready_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    anb_tag_fifo_m #(
        .DEPTH (OUTSTANDING)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (a_fire),
        .push_tag ('{is_final: is_final}),
        .pop      (s_d_valid && s_d_ready && s_d_last),
        .head     (tag_head),
        .full     (tag_full),
        .empty    (tag_empty),
        .count    (tag_count)
    );

    // An orphan beat (no outstanding tag) is still forwarded, but never as a last beat.
    always_comb begin
        d_in      = '0;
        d_in.data = s_d_data;
        d_in.last = s_d_last && !tag_empty && tag_head.is_final;
    end

    reg_stage_m #(
        .T (beat_t)
    ) u_slice (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_d_valid),
        .s_ready (s_d_ready),
        .s_data  (d_in),
        .m_valid (m_d_valid),
        .m_ready (m_d_ready),
        .m_data  (d_out)
    );

    assign m_d_data = d_out.data;
    assign m_d_last = d_out.last;

    a_no_orphan_data: assert property (@(posedge clk) disable iff (rst) s_d_valid |-> !tag_empty)
        else $error("read data beat arrived with no outstanding sub-burst");
    a_count_bound: assert property (@(posedge clk) disable iff (rst) tag_count <= cnt_t'(OUTSTANDING))
        else $error("tag FIFO occupancy exceeds its depth");

endmodule
